// File: rtl/pulse_cnt_pkg.sv
// Shared types and constants for the pulse accumulation counter.
package pulse_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int EDGE_NEG = 0;
    localparam int EDGE_POS = 1;

endpackage

// File: rtl/edge_delay_line.sv
// Registered edge detector on data_valid_i followed by a DLY-stage shift
// register; clr_i empties the detector output and every stage.
module edge_delay_line
    import pulse_cnt_pkg::*;
#(
    parameter int EDGE_MODE = EDGE_NEG,
    parameter int DLY       = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic data_valid_i,
    output logic dly_pls_o
);

    logic           dv_q;
    logic           edge_q;
    logic           edge_d;
    logic [DLY-1:0] sr_q;

    always_comb begin
        if (EDGE_MODE == EDGE_POS) edge_d = data_valid_i & ~dv_q;
        else                       edge_d = dv_q & ~data_valid_i;
    end

    // The level history keeps running through a clear so an edge straddling
    // capture enable is judged on real samples, not on a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q   <= 1'b0;
            edge_q <= 1'b0;
            sr_q   <= '0;
        end else begin
            dv_q <= data_valid_i;
            if (clr_i) begin
                edge_q <= 1'b0;
                sr_q   <= '0;
            end else begin
                edge_q <= edge_d;
                sr_q   <= (sr_q << 1) | DLY'(edge_q);
            end
        end
    end

    assign dly_pls_o = sr_q[DLY-1];

endmodule

// File: rtl/pulse_accum_counter.sv
// Frame pulse counter with first/last flags and frame-done detection.
// Optional watchdog on pulse gaps is built when PLS_TIMEOUT_EN is defined.
//
//  state | meaning
//  IDLE  | capture disabled; outputs cleared, delay line held empty
//  ACCUM | counting delayed pulses toward the sampled target
//  DONE  | target reached; count and acc_done held until capture_en drops
module pulse_accum_counter
    import pulse_cnt_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DLY       = 6,
    parameter int EDGE_MODE = EDGE_NEG,
    parameter int TMO_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_valid_i,
    input  logic             capture_en,
    input  logic [CNT_W-1:0] target_pulses,
    output logic [CNT_W-1:0] pulse_counts,
    output logic             is_first_pls,
    output logic             is_last_pls,
    output logic             acc_done,
    output logic             cnt_wrap,
    output logic             pls_timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             dly_pls;
    logic             clr_dly;

    // Emptying the line on every IDLE cycle, including the enabling one,
    // drops any edge that was seen before capture started.
    assign clr_dly = (state_q == IDLE);

    edge_delay_line #(
        .EDGE_MODE (EDGE_MODE),
        .DLY       (DLY)
    ) u_edge_delay_line (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr_dly),
        .data_valid_i (data_valid_i),
        .dly_pls_o    (dly_pls)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        first_d = 1'b0;
        last_d  = 1'b0;
        done_d  = done_q;
        wrap_d  = wrap_q;
        if (!capture_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            wrap_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACCUM;
                    tgt_d   = target_pulses;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    wrap_d  = 1'b0;
                end
                ACCUM: begin
                    first_d = (cnt_q == '0);
                    last_d  = (tgt_q != '0) && (cnt_q == tgt_q - CNT_ONE);
                    if (dly_pls) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (tgt_q == '0) begin
                            if (cnt_q == '1) wrap_d = 1'b1;
                        end else if (cnt_d == tgt_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            first_q <= first_d;
            last_q  <= last_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign pulse_counts = cnt_q;
    assign is_first_pls = first_q;
    assign is_last_pls  = last_q;
    assign acc_done     = done_q;
    assign cnt_wrap     = wrap_q;

`ifdef PLS_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_flag_q, tmo_flag_d;

    // Down-counter from all-ones: terminal count zero means 2^TMO_W-1
    // pulse-free ACCUM cycles since the last reload.
    always_comb begin
        tmo_d      = tmo_q;
        tmo_flag_d = tmo_flag_q;
        if (!capture_en) begin
            tmo_d      = '1;
            tmo_flag_d = 1'b0;
        end else if (state_q == IDLE) begin
            tmo_d = '1;
        end else if (state_q == ACCUM) begin
            if (tmo_q == '0) tmo_flag_d = 1'b1;
            tmo_d = dly_pls ? '1 : tmo_q - TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q      <= '1;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign pls_timeout = tmo_flag_q;
`else
    // Watchdog compiled out; only a nonsensical negative TMO_W could raise it.
    assign pls_timeout = (TMO_W < 0);
`endif

endmodule

// File: tb/tb_pulse_accum_counter.sv
// Self-checking bench for pulse_accum_counter: directed table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_pulse_accum_counter;

    localparam int CNT_W = 4;
    localparam int DLY   = 6;
    localparam int TMO_W = 8;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int TMO_MAX = (1 << TMO_W) - 1;

`ifdef PLS_TIMEOUT_EN
    localparam logic TMO_ON = 1'b1;
`else
    localparam logic TMO_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             data_valid_i = 1'b0;
    logic             capture_en = 1'b0;
    logic [CNT_W-1:0] target_pulses = '0;
    logic [CNT_W-1:0] pulse_counts;
    logic             is_first_pls, is_last_pls, acc_done, cnt_wrap, pls_timeout;

    pulse_accum_counter #(
        .CNT_W     (CNT_W),
        .DLY       (DLY),
        .EDGE_MODE (0),
        .TMO_W     (TMO_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_valid_i  (data_valid_i),
        .capture_en    (capture_en),
        .target_pulses (target_pulses),
        .pulse_counts  (pulse_counts),
        .is_first_pls  (is_first_pls),
        .is_last_pls   (is_last_pls),
        .acc_done      (acc_done),
        .cnt_wrap      (cnt_wrap),
        .pls_timeout   (pls_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [CNT_W-1:0] tgt;
        int               n_edges;
        int               exp_cnt;
        logic             exp_done;
        logic             exp_wrap;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [CNT_W-1:0] tgt);
        capture_en = 1'b0;
        tick();
        capture_en    = 1'b1;
        target_pulses = tgt;
        tick();
    endtask

    // Returns just after the clock edge that samples the falling edge.
    task automatic edge_fall(input int hold);
        data_valid_i = 1'b1;
        repeat (hold) tick();
        data_valid_i = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_cnt"},   pulse_counts, 0);
        check({name, "_first"}, is_first_pls, 0);
        check({name, "_last"},  is_last_pls, 0);
        check({name, "_done"},  acc_done, 0);
        check({name, "_wrap"},  cnt_wrap, 0);
        check({name, "_tmo"},   pls_timeout, 0);
    endtask

    // Reference model state
    int   m_state;   // 0 idle, 1 accumulating, 2 frame complete
    int   m_cnt, m_tgt, m_k, m_cyc;
    logic m_first, m_last, m_done, m_wrap, m_to, m_dv_prev;
    int   arrivals[$];

    task automatic model_step();
        logic pls, edge_seen;
        int   pre;
        m_cyc++;
        pls = 1'b0;
        if (arrivals.size() > 0 && arrivals[0] == m_cyc) begin
            pls = 1'b1;
            void'(arrivals.pop_front());
        end
        edge_seen = m_dv_prev & ~data_valid_i;
        m_dv_prev = data_valid_i;
        pre = m_state;
        if (pre == 0) arrivals.delete();
        else if (edge_seen) arrivals.push_back(m_cyc + 1 + DLY);

        if (!capture_en) begin
            m_state = 0; m_cnt = 0; m_first = 0; m_last = 0;
            m_done = 0; m_wrap = 0; m_to = 0; m_k = 0;
        end else if (pre == 0) begin
            m_state = 1; m_tgt = int'(target_pulses); m_cnt = 0;
            m_first = 0; m_last = 0; m_k = 0;
        end else if (pre == 1) begin
            if (m_k == TMO_MAX) m_to = 1;
            m_k     = pls ? 0 : (m_k + 1) % (TMO_MAX + 1);
            m_first = (m_cnt == 0);
            m_last  = (m_tgt != 0) && (m_cnt == m_tgt - 1);
            if (pls) begin
                if (m_tgt == 0) begin
                    if (m_cnt == CNT_MOD - 1) m_wrap = 1;
                    m_cnt = (m_cnt + 1) % CNT_MOD;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == m_tgt) begin
                        m_state = 2;
                        m_done  = 1;
                    end
                end
            end
        end else begin
            m_first = 0;
            m_last  = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got run still active expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'd4,  4,  4, 1'b1, 1'b0};
        tbl[1] = '{4'd4,  7,  4, 1'b1, 1'b0};
        tbl[2] = '{4'd0,  17, 1, 1'b0, 1'b1};
        tbl[3] = '{4'd0,  15, 15, 1'b0, 1'b0};
        tbl[4] = '{4'd0,  16, 0, 1'b0, 1'b1};
        tbl[5] = '{4'd1,  1,  1, 1'b1, 1'b0};
        tbl[6] = '{4'd1,  3,  1, 1'b1, 1'b0};
        tbl[7] = '{4'd3,  2,  2, 1'b0, 1'b0};
        tbl[8] = '{4'd15, 20, 15, 1'b1, 1'b0};

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Alignment and flags, target 4, edges 50 cycles apart
        data_valid_i = 1'b1;
        restart(4'd4);
        for (int i = 0; i < 4; i++) begin
            data_valid_i = 1'b1;
            repeat (20) tick();
            data_valid_i = 1'b0;
            tick();
            repeat (DLY) tick();
            check("t1_pre_count", pulse_counts, i);
            tick();
            check("t1_count", pulse_counts, i + 1);
            check("t1_first", is_first_pls, (i == 0));
            check("t1_last",  is_last_pls,  (i == 3));
            check("t1_done",  acc_done,     (i == 3));
            repeat (22) tick();
        end

        // DONE ignores further pulses
        for (int i = 0; i < 3; i++) begin
            edge_fall(4);
            repeat (4) tick();
        end
        repeat (DLY + 2) tick();
        check("t2_count", pulse_counts, 4);
        check("t2_done",  acc_done, 1);
        check("t2_last",  is_last_pls, 0);

        // Table of frames
        for (int v = 0; v < 9; v++) begin
            restart(tbl[v].tgt);
            for (int e = 0; e < tbl[v].n_edges; e++) begin
                edge_fall(4);
                repeat (4) tick();
            end
            repeat (DLY + 3) tick();
            check("tbl_count", pulse_counts, tbl[v].exp_cnt);
            check("tbl_done",  acc_done, tbl[v].exp_done);
            check("tbl_wrap",  cnt_wrap, tbl[v].exp_wrap);
        end

        // Capture drop mid-frame with a pulse still in the delay line
        restart(4'd8);
        edge_fall(4);
        repeat (DLY + 2) tick();
        edge_fall(4);
        repeat (DLY + 2) tick();
        check("t4_count_before", pulse_counts, 2);
        edge_fall(4);
        tick();
        tick();
        capture_en = 1'b0;
        tick();
        check_all_zero("t4_cleared");
        capture_en = 1'b1;
        tick();
        repeat (DLY + 4) tick();
        check("t4_stale", pulse_counts, 0);
        edge_fall(4);
        repeat (DLY + 1) tick();
        check("t4_fresh", pulse_counts, 1);

        // Asynchronous reset mid-frame
        restart(4'd8);
        edge_fall(4);
        repeat (DLY + 2) tick();
        check("t5_count_before", pulse_counts, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_cnt", pulse_counts, 0);
        check("t5_async_first", is_first_pls, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_idle_first", is_first_pls, 0);
        tick();
        check("t5_accum_first", is_first_pls, 1);
        check("t5_accum_cnt", pulse_counts, 0);

        // Watchdog: no pulses in free-run ACCUM
        data_valid_i = 1'b0;
        restart(4'd0);
        repeat (254) tick();
        check("t6_tmo_early", pls_timeout, 0);
        tick();
        check("t6_tmo_edge", pls_timeout, 0);
        tick();
        check("t6_tmo_set", pls_timeout, TMO_ON);
        repeat (100) tick();
        check("t6_tmo_sticky", pls_timeout, TMO_ON);
        capture_en = 1'b0;
        tick();
        check("t6_tmo_clear", pls_timeout, 0);

        // Randomized run against the reference model
        capture_en   = 1'b0;
        data_valid_i = 1'b0;
        tick();
        tick();
        m_state = 0; m_cnt = 0; m_tgt = 0; m_k = 0; m_cyc = 0;
        m_first = 0; m_last = 0; m_done = 0; m_wrap = 0; m_to = 0;
        m_dv_prev = 1'b0;
        arrivals.delete();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) data_valid_i = ~data_valid_i;
            capture_en    = ($urandom_range(0, 199) != 0);
            target_pulses = CNT_W'($urandom_range(0, 6));
            @(posedge clk);
            model_step();
            #1;
            check("rnd_count", pulse_counts, m_cnt);
            check("rnd_first", is_first_pls, m_first);
            check("rnd_last",  is_last_pls, m_last);
            check("rnd_done",  acc_done, m_done);
            check("rnd_wrap",  cnt_wrap, m_wrap);
            check("rnd_tmo",   pls_timeout, m_to & TMO_ON);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
